// File: rtl/aux_perf_monitor.sv
// Run-control block (RUN / HALTED / single-STEP) gating a bank of event counters
// with sticky overflow flags, shadow snapshots and a channel read-out mux.
module aux_perf_monitor #(
    parameter int unsigned ChanCnt = 4,
    parameter int unsigned CntBit  = 32,
    parameter bit          SatMode = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               resume,
    input  logic               step_mode,
    input  logic [ChanCnt-1:0] events,
    input  logic               clr,
    input  logic               snap,
    input  logic [3:0]         sel,
    output logic               en,
    output logic [CntBit-1:0]  cnt_out,
    output logic [CntBit-1:0]  snap_out,
    output logic [ChanCnt-1:0] ovf
);

    localparam logic [CntBit-1:0] CntOne = CntBit'(1);

    // ST_RESET is the state held during reset; it always advances to ST_RUN.
    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_HALTED,
        ST_STEP
    } run_state_e;

    run_state_e         state;
    run_state_e         state_nxt;
    logic               en_nxt;
    logic               resume_q;
    logic               resume_edge;

    logic [CntBit-1:0]  cnt_q    [ChanCnt];
    logic [CntBit-1:0]  shadow_q [ChanCnt];
    logic [ChanCnt-1:0] ovf_q;

    // History resets to 1 so a resume held high through reset is not an edge.
    assign resume_edge = resume & ~resume_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RESET;
            en       <= 1'b0;
            resume_q <= 1'b1;
        end else begin
            state    <= state_nxt;
            en       <= en_nxt;
            resume_q <= resume;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RESET:  state_nxt = ST_RUN;
            ST_RUN:    if (halt) state_nxt = ST_HALTED;
            ST_HALTED: begin
                if (resume_edge) begin
                    state_nxt = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_STEP:   state_nxt = ST_HALTED;
            default:   state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        en_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
    end

    // Shadows take the pre-update value, so snap with clr captures pre-clear counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            for (int unsigned i = 0; i < ChanCnt; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ChanCnt; i++) begin
                if (snap) begin
                    shadow_q[i] <= cnt_q[i];
                end
                if (clr) begin
                    cnt_q[i] <= '0;
                    ovf_q[i] <= 1'b0;
                end else if (en && events[i]) begin
                    if (cnt_q[i] == '1) begin
                        ovf_q[i] <= 1'b1;
                        if (!SatMode) begin
                            cnt_q[i] <= '0;
                        end
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CntOne;
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_out  = '0;
        snap_out = '0;
        for (int unsigned i = 0; i < ChanCnt; i++) begin
            if (32'(sel) == i) begin
                cnt_out  = cnt_q[i];
                snap_out = shadow_q[i];
            end
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_aux_perf_monitor.sv
// Self-checking bench: three parameterisations driven in lockstep and compared
// every cycle against an arithmetic reference model, plus pinned directed checks.
module tb_aux_perf_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       halt = 1'b0;
    logic       resume = 1'b0;
    logic       step_mode = 1'b0;
    logic [3:0] ev = 4'b0000;
    logic       clr = 1'b0;
    logic       snap = 1'b0;
    logic [3:0] sel = 4'd0;

    logic        en_a, en_b, en_c;
    logic [3:0]  cnt_a, snp_a, ovf_a;
    logic [3:0]  cnt_b, snp_b, ovf_b;
    logic [31:0] cnt_c, snp_c;
    logic [2:0]  ovf_c;

    always #5 clk = ~clk;

    aux_perf_monitor #(.ChanCnt(4), .CntBit(4), .SatMode(1'b0)) dut_a (
        .clk(clk), .rst(rst), .halt(halt), .resume(resume), .step_mode(step_mode),
        .events(ev), .clr(clr), .snap(snap), .sel(sel),
        .en(en_a), .cnt_out(cnt_a), .snap_out(snp_a), .ovf(ovf_a)
    );

    aux_perf_monitor #(.ChanCnt(4), .CntBit(4), .SatMode(1'b1)) dut_b (
        .clk(clk), .rst(rst), .halt(halt), .resume(resume), .step_mode(step_mode),
        .events(ev), .clr(clr), .snap(snap), .sel(sel),
        .en(en_b), .cnt_out(cnt_b), .snap_out(snp_b), .ovf(ovf_b)
    );

    aux_perf_monitor #(.ChanCnt(3), .CntBit(32), .SatMode(1'b0)) dut_c (
        .clk(clk), .rst(rst), .halt(halt), .resume(resume), .step_mode(step_mode),
        .events(ev[2:0]), .clr(clr), .snap(snap), .sel(sel),
        .en(en_c), .cnt_out(cnt_c), .snap_out(snp_c), .ovf(ovf_c)
    );

    // Reference model
    int              nch   [3] = '{4, 4, 3};
    longint unsigned maxv  [3] = '{64'd15, 64'd15, 64'hFFFF_FFFF};
    bit              satm  [3] = '{1'b0, 1'b1, 1'b0};
    longint unsigned cnt_m [3][4];
    longint unsigned shd_m [3][4];
    bit              ovf_m [3][4];
    bit              en_m = 1'b0;
    bit              halted_m = 1'b0;
    bit              stepping_m = 1'b0;
    bit              prev_res = 1'b1;
    bit              check_on = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned sel_val(input int k, input bit shadow);
        if (int'(sel) >= nch[k]) return 0;
        return shadow ? shd_m[k][sel] : cnt_m[k][sel];
    endfunction

    function automatic longint unsigned ovf_vec(input int k);
        longint unsigned v = 0;
        for (int c = 0; c < nch[k]; c++) if (ovf_m[k][c]) v |= (64'd1 << c);
        return v;
    endfunction

    always @(posedge clk) begin
        bit redge;
        bit new_en;
        if (rst) begin
            en_m = 1'b0; halted_m = 1'b0; stepping_m = 1'b0; prev_res = 1'b1;
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < 4; c++) begin
                    cnt_m[k][c] = 0; shd_m[k][c] = 0; ovf_m[k][c] = 1'b0;
                end
        end else begin
            redge = resume && !prev_res;
            for (int k = 0; k < 3; k++)
                for (int c = 0; c < nch[k]; c++) begin
                    if (snap) shd_m[k][c] = cnt_m[k][c];
                    if (clr) begin
                        cnt_m[k][c] = 0; ovf_m[k][c] = 1'b0;
                    end else if (en_m && ev[c]) begin
                        if (cnt_m[k][c] == maxv[k]) begin
                            ovf_m[k][c] = 1'b1;
                            if (!satm[k]) cnt_m[k][c] = 0;
                        end else begin
                            cnt_m[k][c] = cnt_m[k][c] + 1;
                        end
                    end
                end
            if (stepping_m) begin
                stepping_m = 1'b0; halted_m = 1'b1; new_en = 1'b0;
            end else if (!halted_m) begin
                // en_m low while not halted means we are just out of reset
                if (en_m && halt) begin halted_m = 1'b1; new_en = 1'b0; end
                else new_en = 1'b1;
            end else if (redge) begin
                halted_m = 1'b0; stepping_m = step_mode; new_en = 1'b1;
            end else begin
                new_en = 1'b0;
            end
            en_m = new_en;
            prev_res = resume;
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            chk("en_a", en_a, en_m);
            chk("en_b", en_b, en_m);
            chk("en_c", en_c, en_m);
            chk("cnt_out_a", cnt_a, sel_val(0, 1'b0));
            chk("cnt_out_b", cnt_b, sel_val(1, 1'b0));
            chk("cnt_out_c", cnt_c, sel_val(2, 1'b0));
            chk("snap_out_a", snp_a, sel_val(0, 1'b1));
            chk("snap_out_b", snp_b, sel_val(1, 1'b1));
            chk("snap_out_c", snp_c, sel_val(2, 1'b1));
            chk("ovf_a", ovf_a, ovf_vec(0));
            chk("ovf_b", ovf_b, ovf_vec(1));
            chk("ovf_c", ovf_c, ovf_vec(2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ones;
        // Reset and plain counting
        rst = 1'b1;
        tick();
        check_on = 1'b1;
        tick();
        chk("rst_en", en_c, 0);
        chk("rst_cnt", cnt_c, 0);
        rst = 1'b0; ev = 4'b0001;
        tick();
        chk("release_en", en_c, 1);
        repeat (10) tick();
        sel = 4'd0; #1;
        chk("run10_cnt0", cnt_c, 10);
        chk("run10_ovf", ovf_c, 0);
        sel = 4'd1; #1;
        chk("run10_cnt1", cnt_c, 0);

        // Halt pulse, then resume
        sel = 4'd0; halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_en", en_c, 0);
        chk("halt_cnt", cnt_c, 11);
        repeat (2) tick();
        chk("frozen_cnt", cnt_c, 11);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_en", en_c, 1);
        chk("resume_cnt", cnt_c, 11);
        tick();
        chk("resumed_cnt", cnt_c, 12);

        // Single step with resume held high
        halt = 1'b1;
        tick();
        halt = 1'b0; step_mode = 1'b1;
        tick();
        resume = 1'b1;
        ones = 0;
        repeat (5) begin
            tick();
            ones += int'(en_c);
        end
        chk("step_en_cycles", ones, 1);
        chk("step_cnt", cnt_c, 14);
        resume = 1'b0;
        tick();
        chk("step_back_halted", en_c, 0);

        // Wrap vs saturate on channel 1
        step_mode = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0; ev = 4'b0000; clr = 1'b1;
        tick();
        clr = 1'b0; ev = 4'b0010;
        repeat (17) tick();
        ev = 4'b0000; sel = 4'd1; #1;
        chk("wrap_cnt1", cnt_a, 1);
        chk("wrap_ovf", ovf_a, 4'b0010);
        chk("sat_cnt1", cnt_b, 15);
        chk("sat_ovf", ovf_b, 4'b0010);
        chk("wide_cnt1", cnt_c, 17);

        // Snap and clear together
        ev = 4'b0100;
        repeat (7) tick();
        snap = 1'b1; clr = 1'b1;
        tick();
        snap = 1'b0; clr = 1'b0; ev = 4'b0000; sel = 4'd2; #1;
        chk("snapclr_shadow", snp_a, 7);
        chk("snapclr_cnt", cnt_a, 0);
        chk("snapclr_ovf", ovf_a, 0);
        chk("snapclr_shadow_c", snp_c, 7);

        // Out-of-range select on the 3-channel instance
        ev = 4'b1111;
        repeat (3) tick();
        ev = 4'b0000; sel = 4'd3; #1;
        chk("sel3_cnt_c", cnt_c, 0);
        chk("sel3_snap_c", snp_c, 0);
        chk("sel3_cnt_a", cnt_a, 3);

        // Reset while in STEP, resume held across release
        halt = 1'b1;
        tick();
        halt = 1'b0; step_mode = 1'b1;
        tick();
        resume = 1'b1;
        tick();
        chk("in_step_en", en_c, 1);
        rst = 1'b1;
        tick();
        chk("step_rst_en", en_c, 0);
        tick();
        rst = 1'b0;
        tick();
        sel = 4'd0; #1;
        chk("post_rst_en", en_c, 1);
        chk("post_rst_cnt", cnt_a, 0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        repeat (2) tick();
        chk("held_resume_no_edge", en_c, 0);
        resume = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            halt      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) resume = ~resume;
            step_mode = $urandom_range(0, 1);
            ev        = 4'($urandom_range(0, 15));
            clr       = ($urandom_range(0, 63) == 0);
            snap      = ($urandom_range(0, 7) == 0);
            sel       = 4'($urandom_range(0, 15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
